// File: rtl/data_sram_ctrl_pkg.sv
// Shared types and constants for the data-side SRAM controller.
// Holds the FSM state encoding and the byte-enable decode used during ACCESS.
package data_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        SRAM_IDLE   = 2'd0,
        SRAM_ACCESS = 2'd1,
        SRAM_DONE   = 2'd2
    } sram_state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [3:0]  BE_NONE_N = 4'b1111;

    // Reads enable every lane; writes enable only the requested lanes (active-low).
    function automatic logic [3:0] access_be_n(input logic is_wr, input logic [3:0] we);
        return is_wr ? ~we : 4'b0000;
    endfunction

endpackage

// File: rtl/data_sram_ctrl.sv
// Data-side memory responder: runs one MEM-stage load/store against an external
// asynchronous SRAM and holds the pipeline until the access has finished.
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic [3:0]        mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_dq_o,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    sram_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              abandoned_q, abandoned_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        we_q, we_d;
    logic              is_wr_q, is_wr_d;

    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [3:0]        be_n_q, be_n_d;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SRAM_IDLE;
            cnt_q       <= 4'd0;
            abandoned_q <= 1'b0;
            rdata_q     <= ZERO_WORD;
            addr_q      <= '0;
            wdata_q     <= ZERO_WORD;
            we_q        <= 4'b0000;
            is_wr_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            be_n_q      <= BE_NONE_N;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abandoned_q <= abandoned_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            is_wr_q     <= is_wr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            be_n_q      <= be_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SRAM_IDLE:   if (mem_ce_i) state_d = SRAM_ACCESS;
            SRAM_ACCESS: if (cnt_q == 4'd0) state_d = SRAM_DONE;
            SRAM_DONE:   state_d = SRAM_IDLE;
            default:     state_d = SRAM_IDLE;
        endcase
    end

    // A flushed access still runs to completion so an SRAM write is never cut short.
    always_comb begin
        cnt_d       = cnt_q;
        abandoned_d = abandoned_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        is_wr_d     = is_wr_q;
        case (state_q)
            SRAM_IDLE: begin
                if (mem_ce_i) begin
                    addr_d      = mem_addr_i[ADDR_W+1:2];
                    wdata_d     = mem_data_i;
                    we_d        = mem_we_i;
                    is_wr_d     = |mem_we_i;
                    cnt_d       = CNT_LOAD;
                    abandoned_d = 1'b0;
                end
            end
            SRAM_ACCESS: begin
                if (!mem_ce_i) abandoned_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    if (!is_wr_q) rdata_d = sram_dq_i;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    // Strobes are decoded from the upcoming state and registered, so the pins never glitch.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        be_n_d  = BE_NONE_N;
        if (state_d == SRAM_ACCESS) begin
            ce_n_d = 1'b0;
            be_n_d = access_be_n(is_wr_d, we_d);
            if (is_wr_d) begin
                dq_oe_d = 1'b1;
                we_n_d  = (cnt_d == 4'd0);
            end else begin
                oe_n_d  = 1'b0;
            end
        end
    end

    assign stallreq_o  = mem_ce_i && !(state_q == SRAM_DONE && !abandoned_q);
    assign mem_data_o  = rdata_q;
    assign sram_addr_o = addr_q;
    assign sram_dq_o   = wdata_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_be_n   = be_n_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: two instances (WAIT_CYCLES 2 and 5), each on its own
// SRAM model, checked against a word-array reference updated per transaction.
module tb_data_sram_ctrl;

    localparam int ADDR_W = 20;
    localparam int NW     = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              ce [2];
    logic [3:0]        we;
    logic [31:0]       addr, wdata;
    logic [31:0]       mdo [2];
    logic              stall [2];
    logic [ADDR_W-1:0] sa [2];
    logic [31:0]       dq_o [2];
    logic [31:0]       dq_i [2];
    logic              dq_oe [2];
    logic              ce_n [2];
    logic              oe_n [2];
    logic              we_n [2];
    logic [3:0]        be_n [2];

    logic [31:0] smem    [2][NW];
    logic [31:0] ref_mem [2][NW];
    int vec  = 0;
    int miss = 0;
    int wait_of [2] = '{2, 5};

    data_sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we), .mem_addr_i(addr),
        .mem_data_i(wdata), .mem_data_o(mdo[0]), .stallreq_o(stall[0]),
        .sram_addr_o(sa[0]), .sram_dq_o(dq_o[0]), .sram_dq_i(dq_i[0]), .sram_dq_oe(dq_oe[0]),
        .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_be_n(be_n[0])
    );

    data_sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(5)) u_dut5 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we), .mem_addr_i(addr),
        .mem_data_i(wdata), .mem_data_o(mdo[1]), .stallreq_o(stall[1]),
        .sram_addr_o(sa[1]), .sram_dq_o(dq_o[1]), .sram_dq_i(dq_i[1]), .sram_dq_oe(dq_oe[1]),
        .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_be_n(be_n[1])
    );

    function automatic logic [31:0] pat(input int k, input int i);
        if (k == 0 && i == 16) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h9E37_79B1) ^ (k == 1 ? 32'h5555_AAAA : 32'h0);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[7:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] w);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (w[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Asynchronous SRAM model: reloads its pattern during reset, writes enabled lanes while strobed.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sram
            assign dq_i[gi] = (!ce_n[gi] && !oe_n[gi]) ? smem[gi][sa[gi][5:0]] : 32'hFFFF_FFFF;
            always @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < NW; i++) smem[gi][i] <= pat(gi, i);
                end else if (!ce_n[gi] && !we_n[gi] && dq_oe[gi]) begin
                    for (int b = 0; b < 4; b++)
                        if (!be_n[gi][b]) smem[gi][sa[gi][5:0]][b*8 +: 8] <= dq_o[gi][b*8 +: 8];
                end
            end
        end
    endgenerate

    task automatic ref_init();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NW; i++) ref_mem[k][i] = pat(k, i);
    endtask

    task automatic go_idle();
        ce[0] = 1'b0;
        ce[1] = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issues one request on instance k and follows it until the stall releases.
    task automatic do_access(input int k, input logic [3:0] w, input logic [31:0] a,
                             input logic [31:0] d, output int stall_n, output int wel_n,
                             output logic [3:0] be_seen, output logic [31:0] rd,
                             output logic [ADDR_W-1:0] sa_seen);
        bit done;
        done = 1'b0;
        stall_n = 0; wel_n = 0; be_seen = 4'hF; rd = '0; sa_seen = '0;
        ce[k] = 1'b1; we = w; addr = a; wdata = d;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!ce_n[k]) sa_seen = sa[k];
            if (!we_n[k]) begin wel_n++; be_seen = be_n[k]; end
            if (stall[k]) stall_n++;
            else begin rd = mdo[k]; done = 1'b1; end
            @(posedge clk); #1;
        end
        vec++;
        if (!done) begin
            miss++;
            $display("FAIL access_timeout: inst %0d stall still high after 40 cycles, required release", k);
        end
        if (w != 4'b0000) ref_mem[k][widx(a)] = merge(ref_mem[k][widx(a)], d, w);
    endtask

    task automatic test_reset();
        rst = 1'b1; ce[0] = 1'b0; ce[1] = 1'b0; we = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vec += 7;
            if (ce_n[k] !== 1'b1)   begin miss++; $display("FAIL reset_ce_n inst %0d: got %b want 1", k, ce_n[k]); end
            if (oe_n[k] !== 1'b1)   begin miss++; $display("FAIL reset_oe_n inst %0d: got %b want 1", k, oe_n[k]); end
            if (we_n[k] !== 1'b1)   begin miss++; $display("FAIL reset_we_n inst %0d: got %b want 1", k, we_n[k]); end
            if (be_n[k] !== 4'hF)   begin miss++; $display("FAIL reset_be_n inst %0d: got %b want 1111", k, be_n[k]); end
            if (dq_oe[k] !== 1'b0)  begin miss++; $display("FAIL reset_dq_oe inst %0d: got %b want 0", k, dq_oe[k]); end
            if (stall[k] !== 1'b0)  begin miss++; $display("FAIL reset_stall inst %0d: got %b want 0", k, stall[k]); end
            if (mdo[k] !== 32'h0)   begin miss++; $display("FAIL reset_rdata inst %0d: got %h want 0", k, mdo[k]); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ref_init();
        $display("reset: strobes and outputs checked on both instances");
    endtask

    task automatic test_read();
        int sn, wl; logic [3:0] bs; logic [31:0] rd; logic [ADDR_W-1:0] sq;
        do_access(0, 4'b0000, 32'h0000_0040, $urandom(), sn, wl, bs, rd, sq);
        vec += 3;
        if (sn != 3)             begin miss++; $display("FAIL read_stall: got %0d want 3", sn); end
        if (rd !== 32'hDEAD_BEEF) begin miss++; $display("FAIL read_data: got %h want deadbeef", rd); end
        if (sq !== 20'h00010)    begin miss++; $display("FAIL read_addr: got %h want 00010", sq); end
        $display("read 0x40: stall=%0d data=%h sram_addr=%h", sn, rd, sq);
        go_idle();
    endtask

    task automatic test_byte_write();
        int sn, wl; logic [3:0] bs; logic [31:0] rd; logic [ADDR_W-1:0] sq;
        do_access(0, 4'b0100, 32'h0000_0041, 32'h5A5A_5A5A, sn, wl, bs, rd, sq);
        vec += 3;
        if (bs !== 4'b1011) begin miss++; $display("FAIL bytewr_be_n: got %b want 1011", bs); end
        if (wl != 1)        begin miss++; $display("FAIL bytewr_we_len: got %0d want 1", wl); end
        if (sn != 3)        begin miss++; $display("FAIL bytewr_stall: got %0d want 3", sn); end
        $display("byte write 0x41: be_n=%b we_low=%0d stall=%0d", bs, wl, sn);
        go_idle();
        do_access(0, 4'b0000, 32'h0000_0040, 32'h0, sn, wl, bs, rd, sq);
        vec++;
        if (rd !== 32'hDE5A_BEEF) begin miss++; $display("FAIL bytewr_readback: got %h want de5abeef", rd); end
        $display("readback 0x40: data=%h", rd);
        go_idle();
    endtask

    task automatic test_back_to_back();
        int sn1, sn2, wl; logic [3:0] bs; logic [31:0] rd1, rd2, exp_ld; logic [ADDR_W-1:0] sq;
        logic [31:0] la, sta, sd; logic [3:0] sw;
        for (int n = 0; n < 4; n++) begin
            la = $urandom(); sta = $urandom(); sd = $urandom(); sw = 4'($urandom_range(1, 15));
            exp_ld = ref_mem[0][widx(la)];
            do_access(0, 4'b0000, la, 32'h0, sn1, wl, bs, rd1, sq);
            do_access(0, sw, sta, sd, sn2, wl, bs, rd2, sq);
            vec += 4;
            if (sn1 != 3)       begin miss++; $display("FAIL b2b_load_stall: got %0d want 3", sn1); end
            if (sn2 != 3)       begin miss++; $display("FAIL b2b_store_stall: got %0d want 3", sn2); end
            if (rd1 !== exp_ld) begin miss++; $display("FAIL b2b_load_data: got %h want %h", rd1, exp_ld); end
            if (rd2 !== exp_ld) begin miss++; $display("FAIL b2b_rdata_hold: got %h want %h", rd2, exp_ld); end
            $display("b2b load %h -> %h, store %h we=%b data=%h", la, rd1, sta, sw, sd);
            go_idle();
        end
    endtask

    task automatic test_flush();
        int sn, wl; logic [3:0] bs; logic [31:0] rd, a_a, a_b, exp_b; logic [ADDR_W-1:0] sq;
        a_a = $urandom(); a_b = $urandom();
        exp_b = ref_mem[0][widx(a_b)];
        ce[0] = 1'b1; we = 4'b0000; addr = a_a;
        @(posedge clk); #1;
        ce[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // DONE of the abandoned read: the new request must stall here and in IDLE.
        do_access(0, 4'b0000, a_b, 32'h0, sn, wl, bs, rd, sq);
        vec += 3;
        if (sn != 4)               begin miss++; $display("FAIL flush_stall: got %0d want 4", sn); end
        if (rd !== exp_b)          begin miss++; $display("FAIL flush_data: got %h want %h", rd, exp_b); end
        if (sq !== a_b[21:2])      begin miss++; $display("FAIL flush_addr: got %h want %h", sq, a_b[21:2]); end
        $display("flush: abandoned %h, new read %h stall=%0d data=%h", a_a, a_b, sn, rd);
        go_idle();
    endtask

    task automatic test_reset_mid_write();
        int sn, wl; logic [3:0] bs; logic [31:0] rd, ra, exp_r; logic [ADDR_W-1:0] sq;
        ce[0] = 1'b1; we = 4'b1111; addr = $urandom(); wdata = $urandom();
        @(posedge clk); #1;
        @(negedge clk);
        vec++;
        if (we_n[0] !== 1'b0) begin miss++; $display("FAIL rstwr_strobe_active: got %b want 0", we_n[0]); end
        rst = 1'b1; ce[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vec += 7;
        if (ce_n[0] !== 1'b1)  begin miss++; $display("FAIL rstwr_ce_n: got %b want 1", ce_n[0]); end
        if (oe_n[0] !== 1'b1)  begin miss++; $display("FAIL rstwr_oe_n: got %b want 1", oe_n[0]); end
        if (we_n[0] !== 1'b1)  begin miss++; $display("FAIL rstwr_we_n: got %b want 1", we_n[0]); end
        if (be_n[0] !== 4'hF)  begin miss++; $display("FAIL rstwr_be_n: got %b want 1111", be_n[0]); end
        if (dq_oe[0] !== 1'b0) begin miss++; $display("FAIL rstwr_dq_oe: got %b want 0", dq_oe[0]); end
        if (stall[0] !== 1'b0) begin miss++; $display("FAIL rstwr_stall: got %b want 0", stall[0]); end
        if (mdo[0] !== 32'h0)  begin miss++; $display("FAIL rstwr_rdata: got %h want 0", mdo[0]); end
        @(posedge clk); #1;
        rst = 1'b0;
        ref_init();
        ra = $urandom(); exp_r = ref_mem[0][widx(ra)];
        do_access(0, 4'b0000, ra, 32'h0, sn, wl, bs, rd, sq);
        vec += 2;
        if (sn != 3)      begin miss++; $display("FAIL rstwr_idle_stall: got %0d want 3", sn); end
        if (rd !== exp_r) begin miss++; $display("FAIL rstwr_idle_data: got %h want %h", rd, exp_r); end
        $display("reset mid-write: strobes released, follow-up read data=%h", rd);
        go_idle();
    endtask

    task automatic test_random(input int k, input int count);
        int sn, wl, w_exp; logic [3:0] bs, w; logic [31:0] rd, a, d, exp_r; logic [ADDR_W-1:0] sq;
        for (int n = 0; n < count; n++) begin
            a = $urandom(); d = $urandom();
            w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            exp_r = ref_mem[k][widx(a)];
            do_access(k, w, a, d, sn, wl, bs, rd, sq);
            w_exp = (w != 4'b0000) ? wait_of[k] - 1 : 0;
            vec += 3;
            if (sn != wait_of[k] + 1) begin miss++; $display("FAIL rand%0d_stall: got %0d want %0d", k, sn, wait_of[k] + 1); end
            if (wl != w_exp)          begin miss++; $display("FAIL rand%0d_we_len: got %0d want %0d", k, wl, w_exp); end
            if (sq !== a[21:2])       begin miss++; $display("FAIL rand%0d_addr: got %h want %h", k, sq, a[21:2]); end
            if (w != 4'b0000) begin
                vec++;
                if (bs !== ~w) begin miss++; $display("FAIL rand%0d_be_n: got %b want %b", k, bs, ~w); end
            end else begin
                vec++;
                if (rd !== exp_r) begin miss++; $display("FAIL rand%0d_data: got %h want %h", k, rd, exp_r); end
            end
            $display("inst %0d %s addr=%h we=%b stall=%0d we_low=%0d data=%h", k,
                     (w != 4'b0000) ? "write" : "read ", a, w, sn, wl, rd);
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_back_to_back();
        test_flush();
        test_reset_mid_write();
        test_random(1, 12);
        test_random(0, 16);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
